stopwatch_unit: RTL and testbench

//  Minutes:seconds stopwatch with start/stop/reset pushbutton-level controls and a
//  2-bit run-status output. Top-level timing block (stopwatch_top); drives a display
//  or monitor directly. One seconds tick is derived from the system clock by a prescaler.

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/stopwatch_if.sv | 26 ++
 rtl/sw_tick_gen.sv | 37 +++
 rtl/stopwatch_unit.sv | 85 ++++++++
 tb/tb_stopwatch_unit.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch block.
//   sw_state_t : FSM state; the encoding doubles as the external 2-bit status
//                (00 idle, 01 running, 10 paused; 11 is never produced)
//   SEC_MAX    : last seconds value before the minutes carry
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10
   } sw_state_t;

   localparam logic [5:0] SEC_MAX = 6'd59;

endpackage

// File: rtl/stopwatch_if.sv
// Control/display bundle of the stopwatch.
//   start, stop, reset : level controls from the operator (master drives)
//   minutes, seconds   : elapsed time, binary
//   status             : 00 idle, 01 running, 10 paused
// All signals are levels sampled/updated on the rising edge of the system clock;
// there is no valid/ready handshake, every edge is a transfer.
interface stopwatch_if;

   logic       start;
   logic       stop;
   logic       reset;
   logic [7:0] minutes;
   logic [5:0] seconds;
   logic [1:0] status;

   modport master (
      output start, stop, reset,
      input  minutes, seconds, status
   );

   modport slave (
      input  start, stop, reset,
      output minutes, seconds, status
   );

endinterface

// File: rtl/sw_tick_gen.sv
// Seconds prescaler.
//   clk, rst_n : system clock, synchronous active-low reset
//   enable     : count this cycle (stopwatch running)
//   clear      : return the count to zero (idle or operator reset)
//   tick       : high on the cycle the count sits at its terminal value while enabled
// While neither enabled nor cleared the count is held, so a pause keeps the
// fraction of the current second.
module sw_tick_gen #(
   parameter int TICKS_PER_SEC = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   // Keep at least one bit so TICKS_PER_SEC=1 still yields a legal vector.
   localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CW-1:0] TERM = CW'(TICKS_PER_SEC - 1);

   logic [CW-1:0] cnt;

   assign tick = enable && (cnt == TERM);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         if (cnt == TERM) cnt <= '0;
         else             cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/stopwatch_unit.sv
// Minutes:seconds stopwatch.
//   clk     : system clock, rising edge
//   rst_n   : synchronous active-low reset, overrides everything
//   bus     : stopwatch_if.slave
//             start/stop/reset level controls in,
//             minutes (0..MAX_MIN), seconds (0..59), status (= FSM state) out
// Priority at every edge: rst_n > reset > stop > start. The count step uses the
// state held before the edge, so the edge that samples stop still counts and the
// edge that samples start from idle/paused does not.
module stopwatch_unit
   import stopwatch_pkg::*;
#(
   parameter int TICKS_PER_SEC = 1,
   parameter int MAX_MIN       = 99
) (
   input  logic        clk,
   input  logic        rst_n,
   stopwatch_if.slave  bus
);

   localparam logic [7:0] MIN_MAX = 8'(MAX_MIN);

   sw_state_t  state;
   logic [7:0] min_q;
   logic [5:0] sec_q;
   logic       tick;
   logic       tick_en;
   logic       tick_clr;

   // An operator reset must not let the prescaler advance on the clearing edge.
   assign tick_en  = (state == ST_RUN) && !bus.reset;
   assign tick_clr = bus.reset || (state == ST_IDLE);

   sw_tick_gen #(
      .TICKS_PER_SEC (TICKS_PER_SEC)
   ) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (tick_en),
      .clear  (tick_clr),
      .tick   (tick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         min_q <= '0;
         sec_q <= '0;
      end else if (bus.reset) begin
         state <= ST_IDLE;
         min_q <= '0;
         sec_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               // stop outranks start, so both together keep us idle
               if (!bus.stop && bus.start) state <= ST_RUN;
            end
            ST_RUN: begin
               if (bus.stop) state <= ST_PAUSE;
            end
            ST_PAUSE: begin
               if (!bus.stop && bus.start) state <= ST_RUN;
            end
            default: state <= ST_IDLE;
         endcase

         // tick is only ever high while the pre-edge state is running
         if (tick) begin
            if (sec_q == SEC_MAX) begin
               sec_q <= '0;
               if (min_q == MIN_MAX) min_q <= '0;
               else                  min_q <= min_q + 8'd1;
            end else begin
               sec_q <= sec_q + 6'd1;
            end
         end
      end
   end

   assign bus.minutes = min_q;
   assign bus.seconds = sec_q;
   assign bus.status  = state;

endmodule

// File: tb/tb_stopwatch_unit.sv
// Bench for stopwatch_unit (TICKS_PER_SEC=1, MAX_MIN=99): directed scenarios
// followed by a randomized control sequence, both checked against a model that
// tracks elapsed time as a plain count of seconds.
module tb_stopwatch_unit;

   localparam int MAX_MIN  = 99;
   localparam int WRAP_SEC = (MAX_MIN + 1) * 60;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   stopwatch_if sw ();

   stopwatch_unit #(
      .TICKS_PER_SEC (1),
      .MAX_MIN       (MAX_MIN)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sw)
   );

   // ---------------- reference model ----------------
   // mode: 0 idle, 1 running, 2 paused; elapsed: total seconds counted
   int mode;
   int elapsed;

   int total;
   int bad;

   logic [15:0] exp_q[$];

   task automatic model_edge(input logic r_n, input logic s, input logic p, input logic r);
      if (!r_n || r) begin
         mode    = 0;
         elapsed = 0;
      end else begin
         if (mode == 1) elapsed = (elapsed + 1) % WRAP_SEC;
         if (p) begin
            if (mode == 1) mode = 2;
         end else if (s) begin
            mode = 1;
         end
      end
   endtask

   function automatic logic [15:0] model_word();
      logic [7:0] m;
      logic [5:0] s;
      logic [1:0] st;
      m  = 8'(elapsed / 60);
      s  = 6'(elapsed % 60);
      st = 2'(mode);
      return {m, s, st};
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check_model(input string tag);
      logic [15:0] got;
      logic [15:0] exp;
      exp_q.push_back(model_word());
      exp = exp_q.pop_front();
      got = {sw.minutes, sw.seconds, sw.status};
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %0d:%0d st=%b exp %0d:%0d st=%b", tag,
                got[15:8], got[7:2], got[1:0], exp[15:8], exp[7:2], exp[1:0]);
      end
   endtask

   task automatic check_const(input string tag, input int m, input int s, input logic [1:0] st);
      logic [15:0] got;
      logic [15:0] exp;
      exp = {8'(m), 6'(s), st};
      got = {sw.minutes, sw.seconds, sw.status};
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %0d:%0d st=%b exp %0d:%0d st=%b", tag,
                got[15:8], got[7:2], got[1:0], m, s, st);
      end
   endtask

   // ---------------- drivers ----------------
   // Inputs change 1 time unit after the rising edge and are sampled by the next one.
   task automatic cyc(input logic r_n, input logic s, input logic p, input logic r, input string tag);
      rst_n    = r_n;
      sw.start = s;
      sw.stop  = p;
      sw.reset = r;
      @(posedge clk);
      model_edge(r_n, s, p, r);
      #1;
      check_model(tag);
   endtask

   task automatic idle_cycles(input int n, input string tag);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, tag);
   endtask

   task automatic fresh_start();
      cyc(1'b1, 1'b0, 1'b0, 1'b1, "clear");
      cyc(1'b1, 1'b1, 1'b0, 1'b0, "start");
   endtask

   // ---------------- stimulus ----------------
   initial begin
      total    = 0;
      bad      = 0;
      mode     = 0;
      elapsed  = 0;
      rst_n    = 1'b0;
      sw.start = 1'b0;
      sw.stop  = 1'b0;
      sw.reset = 1'b0;

      // 1: power-on reset, then sit idle
      cyc(1'b0, 1'b0, 1'b0, 1'b0, "rst0");
      cyc(1'b0, 1'b0, 1'b0, 1'b0, "rst1");
      check_const("reset_state", 0, 0, 2'b00);
      idle_cycles(5, "idle_no_start");
      check_const("idle_hold", 0, 0, 2'b00);

      // 2: one-cycle start pulse then 125 counted edges
      cyc(1'b1, 1'b1, 1'b0, 1'b0, "start_pulse");
      check_const("start_latency", 0, 0, 2'b01);
      idle_cycles(125, "run125");
      check_const("run_02_05", 2, 5, 2'b01);

      // 3: pause at 01:30; the pausing edge still counts
      fresh_start();
      idle_cycles(90, "run90");
      check_const("at_01_30", 1, 30, 2'b01);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, "stop_pulse");
      check_const("paused", 1, 31, 2'b10);
      idle_cycles(40, "frozen");
      check_const("frozen_40", 1, 31, 2'b10);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, "resume");
      check_const("resume_edge", 1, 31, 2'b01);
      idle_cycles(1, "resume_next");
      check_const("resume_count", 1, 32, 2'b01);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, "start_held_run");
      check_const("start_held_noop", 1, 33, 2'b01);

      // 4: start and stop together
      cyc(1'b1, 1'b0, 1'b0, 1'b1, "clear4");
      cyc(1'b1, 1'b1, 1'b1, 1'b0, "both_idle");
      check_const("both_from_idle", 0, 0, 2'b00);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, "start4");
      idle_cycles(3, "run3");
      cyc(1'b1, 1'b1, 1'b1, 1'b0, "both_run");
      check_const("both_from_run", 0, 4, 2'b10);

      // 5: roll over 99:59 -> 00:00
      fresh_start();
      idle_cycles(WRAP_SEC - 1, "run_to_max");
      check_const("at_99_59", 99, 59, 2'b01);
      idle_cycles(1, "wrap");
      check_const("wrap_00_00", 0, 0, 2'b01);

      // 6: operator reset while running, then stop in idle
      fresh_start();
      idle_cycles(310, "run310");
      check_const("at_05_10", 5, 10, 2'b01);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, "reset_run");
      check_const("reset_clears", 0, 0, 2'b00);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, "stop_idle");
      check_const("stop_in_idle", 0, 0, 2'b00);

      // randomized control sequence against the model
      for (int i = 0; i < 600; i++) begin
         int r;
         logic r_n, s, p, c;
         r   = $urandom_range(0, 99);
         r_n = (r >= 2);
         c   = (r >= 2 && r < 5);
         s   = ($urandom_range(0, 9) < 3);
         p   = ($urandom_range(0, 9) < 2);
         cyc(r_n, s, p, c, "random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
